// File: rtl/joy_serial_mp.sv
`default_nettype none
// ============================================================================
//  Module   : joy_serial_mp
//  Purpose  : Scanner for a chain of serial (parallel-in / serial-out)
//             game controllers. Each frame pulses JOY_LOAD low, then
//             clocks PLAYERS*BITS bits out of the chain on JOY_CLK.
//             The bits are inverted (the chain is active-low) and
//             collected in a shadow register. That register is committed
//             to the joystick output in one cycle, followed by an idle gap.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PLAYERS    controllers in the chain (1..4)
//    BITS       buttons per controller (1..16)
//    CLK_DIV    clk_sys cycles per tick (>= 2)
//    GAP_TICKS  idle ticks between frames (>= 1)
//  Ports
//    clk_sys     in   system clock, rising edge
//    reset_n     in   asynchronous active-low reset
//    enable      in   start / continue scanning while high
//    JOY_DATA    in   serial data from the chain (active-low buttons)
//    JOY_CLK     out  shift clock to the chain
//    JOY_LOAD    out  active-low parallel load to the chain
//    joystick    out  button states, 1 = pressed, player p at [p*BITS +: BITS]
//    frame_done  out  one-cycle pulse on each joystick update
//    busy        out  high whenever the scanner is not idle
//  Build option
//    JOY_SERIAL_DEBOUNCE_EN  when defined, a joystick bit changes only after
//                            two consecutive frames agree on its value
// ============================================================================
module joy_serial_mp #(
    parameter int PLAYERS   = 2,
    parameter int BITS      = 12,
    parameter int CLK_DIV   = 16,
    parameter int GAP_TICKS = 64
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    JOY_DATA,
    output logic                    JOY_CLK,
    output logic                    JOY_LOAD,
    output logic [PLAYERS*BITS-1:0] joystick,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int c_n        = PLAYERS * BITS;
    localparam int c_idx_w    = (c_n > 1) ? $clog2(c_n) : 1;
    localparam int c_div_w    = $clog2(CLK_DIV);
    // One counter covers both the 2-tick LOAD phase and the GAP phase.
    localparam int c_tick_max = (GAP_TICKS > 2) ? GAP_TICKS : 2;
    localparam int c_tcnt_w   = $clog2(c_tick_max);

    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(c_n - 1);
    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_tcnt_w-1:0] c_load_last = c_tcnt_w'(1);
    localparam logic [c_tcnt_w-1:0] c_gap_last  = c_tcnt_w'(GAP_TICKS - 1);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_load     = 3'd1;
    localparam logic [2:0] c_st_shift_lo = 3'd2;
    localparam logic [2:0] c_st_shift_hi = 3'd3;
    localparam logic [2:0] c_st_commit   = 3'd4;
    localparam logic [2:0] c_st_gap      = 3'd5;

    logic [1:0]          r_rst_sync;
    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_div_w-1:0]  r_div;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_n-1:0]      r_shadow;
    logic [c_n-1:0]      w_joy_commit;
    logic                w_tick;
    logic                w_commit_nxt;

    // Two-flop release: the FSM may only leave IDLE once r_rst_sync[1] is set.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_tick = (r_div == c_div_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (enable && r_rst_sync[1]) begin
                    w_state_nxt = c_st_load;
                end
            end
            c_st_load: begin
                if (w_tick && (r_tcnt == c_load_last)) begin
                    w_state_nxt = c_st_shift_lo;
                end
            end
            c_st_shift_lo: begin
                if (w_tick) begin
                    w_state_nxt = c_st_shift_hi;
                end
            end
            c_st_shift_hi: begin
                if (w_tick) begin
                    w_state_nxt = (r_idx == c_idx_last) ? c_st_commit : c_st_shift_lo;
                end
            end
            c_st_commit: begin
                w_state_nxt = c_st_gap;
            end
            c_st_gap: begin
                // The only point where enable decides whether scanning ends.
                if (w_tick && (r_tcnt == c_gap_last)) begin
                    w_state_nxt = enable ? c_st_load : c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // COMMIT lasts one cycle, so a next-state of COMMIT marks its entry edge.
    assign w_commit_nxt = (w_state_nxt == c_st_commit);

`ifdef JOY_SERIAL_DEBOUNCE_EN
    logic [c_n-1:0] r_prev;
    logic [c_n-1:0] w_stable;

    assign w_stable     = ~(r_shadow ^ r_prev);
    assign w_joy_commit = (joystick & ~w_stable) | (r_shadow & w_stable);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
        end else if (w_commit_nxt) begin
            r_prev <= r_shadow;
        end
    end
`else
    assign w_joy_commit = r_shadow;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_idle;
            r_div      <= '0;
            r_tcnt     <= '0;
            r_idx      <= '0;
            r_shadow   <= '0;
            JOY_CLK    <= 1'b0;
            JOY_LOAD   <= 1'b1;
            joystick   <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Prescaler is parked at zero in IDLE and COMMIT so that every
            // timed state starts with a full tick period.
            if ((r_state == c_st_idle) || (r_state == c_st_commit) || w_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + c_div_w'(1);
            end

            if (w_state_nxt != r_state) begin
                r_tcnt <= '0;
            end else if (w_tick) begin
                r_tcnt <= r_tcnt + c_tcnt_w'(1);
            end

            if (r_state == c_st_load) begin
                r_idx <= '0;
            end else if ((r_state == c_st_shift_hi) && w_tick && (r_idx != c_idx_last)) begin
                r_idx <= r_idx + c_idx_w'(1);
            end

            if ((r_state == c_st_shift_lo) && w_tick) begin
                for (int i = 0; i < c_n; i++) begin
                    if (r_idx == c_idx_w'(i)) begin
                        r_shadow[i] <= ~JOY_DATA;
                    end
                end
            end

            // Outputs are registered from the next state so they line up
            // with the state they belong to.
            JOY_CLK    <= (w_state_nxt == c_st_shift_hi);
            JOY_LOAD   <= (w_state_nxt != c_st_load);
            busy       <= (w_state_nxt != c_st_idle);
            frame_done <= w_commit_nxt;
            if (w_commit_nxt) begin
                joystick <= w_joy_commit;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_joy_serial_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_joy_serial_mp
//  Purpose  : Self-checking bench for joy_serial_mp. Two instances:
//             a 2x12 chain at CLK_DIV=4 / GAP_TICKS=4, and a 1x1 chain at
//             CLK_DIV=2 / GAP_TICKS=1. Each has a behavioural shift-register
//             chain model and a frame-level expected-joystick model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_joy_serial_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset_n;
    logic        m_en, m_data, m_jclk, m_jload, m_fd, m_busy;
    logic [23:0] m_joy;
    logic        s_en, s_data, s_jclk, s_jload, s_fd, s_busy;
    logic [0:0]  s_joy;

    joy_serial_mp #(.PLAYERS(2), .BITS(12), .CLK_DIV(4), .GAP_TICKS(4)) u_dut_m (
        .clk_sys(clk), .reset_n(reset_n), .enable(m_en), .JOY_DATA(m_data),
        .JOY_CLK(m_jclk), .JOY_LOAD(m_jload), .joystick(m_joy),
        .frame_done(m_fd), .busy(m_busy)
    );

    joy_serial_mp #(.PLAYERS(1), .BITS(1), .CLK_DIV(2), .GAP_TICKS(1)) u_dut_s (
        .clk_sys(clk), .reset_n(reset_n), .enable(s_en), .JOY_DATA(s_data),
        .JOY_CLK(s_jclk), .JOY_LOAD(s_jload), .joystick(s_joy),
        .frame_done(s_fd), .busy(s_busy)
    );

    // Controller chain: parallel load while LOAD is low, shift towards
    // bit 0 on each rising JOY_CLK, released (1) bits fill in at the far end.
    logic [23:0] m_pat, m_chain;
    always @(posedge m_jclk or negedge m_jload) begin
        if (!m_jload) m_chain <= m_pat;
        else          m_chain <= {1'b1, m_chain[23:1]};
    end
    assign m_data = m_chain[0];

    logic s_pat, s_chain;
    always @(posedge s_jclk or negedge s_jload) begin
        if (!s_jload) s_chain <= s_pat;
        else          s_chain <= 1'b1;
    end
    assign s_data = s_chain;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected joystick state and last seen frame for each instance.
    logic [23:0] m_exp, m_prev;
    logic        s_exp, s_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A frame's pressed-button vector is the inverted chain pattern.
    task automatic m_model(input logic [23:0] pat);
        logic [23:0] cur;
        logic [23:0] same;
        cur  = ~pat;
        same = ~(cur ^ m_prev);
`ifdef JOY_SERIAL_DEBOUNCE_EN
        m_exp = (m_exp & ~same) | (cur & same);
`else
        m_exp = cur | (same & 24'h0);
`endif
        m_prev = cur;
    endtask

    task automatic s_model(input logic pat);
        logic cur;
        logic same;
        cur  = ~pat;
        same = ~(cur ^ s_prev);
`ifdef JOY_SERIAL_DEBOUNCE_EN
        s_exp = (s_exp & ~same) | (cur & same);
`else
        s_exp = cur | (same & 1'b0);
`endif
        s_prev = cur;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return m_busy;
            1:       return m_fd;
            2:       return m_jload;
            3:       return m_jclk;
            4:       return s_fd;
            5:       return s_jload;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait on the following negedges; 'at' = cycle of the event edge.
    task automatic wait_for(input int sel, input logic val, input int max_cyc,
                            input string tag, output int at);
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (sig(sel) === val) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_frame_m(input logic [23:0] pat, input string tag, output int at);
        m_pat = pat;
        wait_for(1, 1'b1, 400, tag, at);
        m_model(pat);
        check(tag, 32'(m_joy), 32'(m_exp));
    endtask

    initial begin
        int t0, tb, tf, tl, tbusy, nfd, nfd2;
        reset_n = 1'b0;
        m_en    = 1'b0;
        s_en    = 1'b0;
        m_pat   = '1;
        s_pat   = 1'b1;
        m_exp   = '0;
        m_prev  = '0;
        s_exp   = 1'b0;
        s_prev  = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_joystick", 32'(m_joy), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_load", 32'(m_jload), 32'd1);
        check("rst_jclk", 32'(m_jclk), 32'd0);
        check("rst_fd", 32'(m_fd), 32'd0);

        // First frame: latency from LOAD entry and a single pressed bit 0.
        m_pat   = 24'hFFFFFE;
        m_en    = 1'b1;
        reset_n = 1'b1;
        t0      = cyc;
        wait_for(0, 1'b1, 20, "start", tb);
        check("rst_release_delay", 32'((tb - t0 >= 2) && (tb - t0 <= 3)), 32'd1);
        check("load_with_busy", 32'(m_jload), 32'd0);
        run_frame_m(24'hFFFFFE, "first_frame_joy", tf);
        check("first_frame_latency", 32'(tf - tb), 32'd200);
        @(negedge clk);
        check("fd_width", 32'(m_fd), 32'd0);

        // Player/bit mapping.
        run_frame_m({12'h0F0, 12'hF0F}, "player_map", tf);

        // Single-frame glitch on bit 3 versus a held press.
        run_frame_m(24'hFFFFFF, "glitch_base0", tf);
        run_frame_m(24'hFFFFFF, "glitch_base1", tf);
        run_frame_m(24'hFFFFF7, "glitch_pulse", tf);
        run_frame_m(24'hFFFFFF, "glitch_after", tf);
        run_frame_m(24'hFFFFF7, "held_first", tf);
        run_frame_m(24'hFFFFF7, "held_second", tf);

        for (int i = 0; i < 4; i++) begin
            run_frame_m(24'($urandom), $sformatf("random_%0d", i), tf);
        end

        // Drop enable during bit 10 of the next frame.
        wait_for(2, 1'b0, 40, "next_load", tl);
        repeat (2 * 4 + 10 * 2 * 4 + 2) @(negedge clk);
        m_en  = 1'b0;
        nfd   = 0;
        tf    = -1;
        tbusy = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (m_fd) begin
                nfd++;
                tf = cyc;
                m_model(m_pat);
            end
            if (!m_busy) begin
                tbusy = cyc;
                break;
            end
        end
        check("drop_en_frames", 32'(nfd), 32'd1);
        // GAP starts the cycle after frame_done and lasts GAP_TICKS*CLK_DIV.
        check("drop_en_busy_fall", 32'(tbusy - tf), 32'd17);
        check("drop_en_joy", 32'(m_joy), 32'(m_exp));
        nfd2 = 0;
        repeat (40) begin
            @(negedge clk);
            if (m_fd || m_busy) nfd2++;
        end
        check("idle_stays_idle", 32'(nfd2), 32'd0);

        // Reset pulse during SHIFT_HI.
        m_en  = 1'b1;
        m_pat = 24'($urandom);
        wait_for(0, 1'b1, 20, "restart", tb);
        wait_for(3, 1'b1, 100, "shift_hi", tb);
        reset_n = 1'b0;
        #1;
        check("midrst_load", 32'(m_jload), 32'd1);
        check("midrst_jclk", 32'(m_jclk), 32'd0);
        check("midrst_joy", 32'(m_joy), 32'd0);
        check("midrst_busy", 32'(m_busy), 32'd0);
        check("midrst_fd", 32'(m_fd), 32'd0);
        m_exp  = '0;
        m_prev = '0;
        s_exp  = 1'b0;
        s_prev = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_frame_m(24'($urandom), "post_reset_frame0", tf);
        run_frame_m(24'($urandom), "post_reset_frame1", tf);

        // Minimal 1-bit chain.
        s_pat = 1'b0;
        s_en  = 1'b1;
        wait_for(5, 1'b0, 20, "s_load", tl);
        wait_for(4, 1'b1, 50, "s_frame0", tf);
        s_model(1'b0);
        check("s_latency", 32'(tf - tl), 32'd8);
        check("s_joy0", 32'(s_joy), 32'(s_exp));
        @(negedge clk);
        check("s_fd_width", 32'(s_fd), 32'd0);
        s_pat = 1'b1;
        wait_for(4, 1'b1, 50, "s_frame1", tf);
        s_model(1'b1);
        check("s_joy1", 32'(s_joy), 32'(s_exp));
        s_pat = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_for(4, 1'b1, 50, "s_frame_p", tf);
            s_model(1'b0);
            check($sformatf("s_joy_press_%0d", i), 32'(s_joy), 32'(s_exp));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/joy_serial_mp.md
JOY_SERIAL_MP -- requirements
Module: joy_serial_mp

Interface
REQ-001 The block SHALL have parameter PLAYERS, default 2, the number of serially chained controllers (legal 1..4).
REQ-002 The block SHALL have parameter BITS, default 12, the buttons per controller (legal 1..16).
REQ-003 The block SHALL have parameter CLK_DIV, default 16, the clk_sys cycles per tick (legal >= 2).
REQ-004 The block SHALL have parameter GAP_TICKS, default 64, the idle ticks between frames (legal >= 1).
REQ-005 The block SHALL have port clk_sys, input, 1 bit, the single clock; one clock, all logic on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit, which starts and continues scanning while high.
REQ-008 The block SHALL have port JOY_DATA, input, 1 bit, the serial data from the shift-register chain, active-low buttons.
REQ-009 The block SHALL have port JOY_CLK, output, 1 bit, the shift clock to the chain.
REQ-010 The block SHALL have port JOY_LOAD, output, 1 bit, the active-low parallel load to the chain.
REQ-011 The block SHALL have port joystick, output, PLAYERS*BITS bits, the button states with 1 = pressed; player p occupies [p*BITS +: BITS].
REQ-012 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse on each joystick update opportunity.
REQ-013 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-014 The prescaler SHALL count 0..CLK_DIV-1 and SHALL assert tick in the cycle its count equals CLK_DIV-1; it SHALL be held at 0 in IDLE and COMMIT.
REQ-015 The FSM SHALL have states IDLE, LOAD, SHIFT_LO, SHIFT_HI, COMMIT and GAP.
REQ-016 IDLE SHALL move to LOAD when enable=1 and otherwise hold, with joystick unchanged.
REQ-017 LOAD SHALL drive JOY_LOAD=0 and JOY_CLK=0 for 2 ticks, then go to SHIFT_LO with bit index 0.
REQ-018 SHIFT_LO SHALL drive JOY_CLK=0; at its tick it SHALL sample ~JOY_DATA into shadow[index], then go to SHIFT_HI.
REQ-019 SHIFT_HI SHALL drive JOY_CLK=1; at its tick, if index = PLAYERS*BITS-1 it SHALL go to COMMIT, else it SHALL increment index and go to SHIFT_LO.
REQ-020 The first sampled bit SHALL map to joystick[0], and bits SHALL be in ascending order.
REQ-021 COMMIT SHALL last one cycle, SHALL update joystick from shadow (see REQ-031), SHALL pulse frame_done, and SHALL go to GAP.
REQ-022 GAP SHALL wait GAP_TICKS ticks with JOY_LOAD=1 and JOY_CLK=0, then go to LOAD if enable=1, else IDLE.
REQ-023 Deasserting enable mid-frame SHALL NOT abort the frame; the frame SHALL complete and the exit SHALL be decided at the end of GAP.
REQ-024 Frame latency from LOAD entry to the frame_done cycle SHALL be CLK_DIV*(2+2*PLAYERS*BITS) cycles.
REQ-025 Counter widths SHALL be $clog2-sized with no wrap inside a frame; the index counter SHALL never exceed PLAYERS*BITS-1.
REQ-026 All outputs SHALL be registered, with no combinational path from JOY_DATA to any output.

Reset
REQ-027 While reset_n=0, the block SHALL immediately drive FSM=IDLE, JOY_CLK=0, JOY_LOAD=1, joystick=0, frame_done=0, busy=0, and clear all counters and shadow.
REQ-028 A reset asserted mid-frame SHALL discard the partial frame; after release, scanning SHALL restart from LOAD (given enable=1) with no stale shadow bits committed.
REQ-029 Reset release SHALL be synchronised internally with a 2-flop release so the FSM leaves IDLE no earlier than the 2nd clk_sys edge after reset_n rises.

Configuration
REQ-030 When macro JOY_SERIAL_DEBOUNCE_EN is defined, the block SHALL keep a previous-frame copy, and each joystick bit SHALL update at COMMIT only if shadow equals that copy for that bit (two consecutive identical frames); otherwise the bit SHALL hold.
REQ-031 When JOY_SERIAL_DEBOUNCE_EN is undefined, COMMIT SHALL copy shadow directly to joystick, and no previous-frame storage SHALL be synthesised.

Verification
REQ-032 With PLAYERS=2, BITS=12, CLK_DIV=4 and enable=1, a chain model returning 24'hFFFFFE (active-low) SHALL yield first frame_done exactly 200 cycles after LOAD entry, with joystick=24'h000001.
REQ-033 With PLAYERS=2, BITS=12, chain pattern p0=12'hF0F, p1=12'h0F0 (active-low) SHALL yield joystick[11:0]=12'h0F0 and joystick[23:12]=12'hF0F.
REQ-034 Dropping enable during SHIFT bit 10 SHALL complete the frame with exactly one frame_done, and busy SHALL fall GAP_TICKS*CLK_DIV cycles later.
REQ-035 Pulsing reset_n low during SHIFT_HI SHALL immediately drive JOY_LOAD=1, JOY_CLK=0, joystick=0 and busy=0, and the next frame SHALL report clean values.
REQ-036 With JOY_SERIAL_DEBOUNCE_EN, a single-frame glitch on bit 3 SHALL leave joystick[3]=0, while two identical frames with bit 3 pressed SHALL set joystick[3]=1 at the second frame_done.
REQ-037 With PLAYERS=1, BITS=1, CLK_DIV=2, a 1-bit frame SHALL complete in 8 cycles with frame_done high for exactly 1 cycle.
